// File: rtl/imem_responder_if.sv
// Fetch/response/load bundle between the HAL CPU and imem_responder.
// The CPU side uses the master modport; the responder uses slave.
interface imem_responder_if #(
  parameter int AW = 13,
  parameter int DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [15:0]   fetch_cnt;

  modport master (
    output req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, resp_valid, resp_data, resp_err, fetch_cnt
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
    output req_ready, resp_valid, resp_data, resp_err, fetch_cnt
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction store with run-time load port and a 2-entry in-order response FIFO.
// Define IMEM_BOUNDS_CHECK_EN to flag fetches at or beyond DEPTH instead of wrapping.
module imem_responder #(
  parameter int DEPTH = 8,
  parameter int AW    = 13,
  parameter int DW    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  imem_responder_if.slave   bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // FIFO occupancy; the head register always presents the oldest entry.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_load_head;
  logic          w_head_from_tail;
  logic          w_load_tail;
  logic [DW-1:0] w_rd_data;
  logic          w_rd_err;
  logic [DW-1:0] r_head_data;
  logic          r_head_err;
  logic [DW-1:0] r_tail_data;
  logic          r_tail_err;
  logic [15:0]   r_fetch_cnt;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_unused_addr;

  assign bus.req_ready  = (r_state != S_FULL);
  assign bus.resp_valid = (r_state != S_EMPTY);
  assign bus.resp_data  = r_head_data;
  assign bus.resp_err   = r_head_err;
  assign bus.fetch_cnt  = r_fetch_cnt;

  assign w_push = bus.req_valid && bus.req_ready;
  assign w_pop  = bus.resp_valid && bus.resp_ready;

`ifdef IMEM_BOUNDS_CHECK_EN
  logic w_oob;
  assign w_oob     = ({1'b0, bus.req_addr} >= (AW+1)'(DEPTH));
  assign w_rd_data = w_oob ? '0 : r_mem[bus.req_addr[IW-1:0]];
  assign w_rd_err  = w_oob;
`else
  assign w_rd_data = r_mem[bus.req_addr[IW-1:0]];
  assign w_rd_err  = 1'b0;
`endif

  // Upper address bits are ignored whenever the store wraps.
  assign w_unused_addr = ^{bus.req_addr, bus.ld_addr};

  // NOTE: the store has no reset; keeping it out of the async-reset block lets it map to RAM.
  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      r_mem[bus.ld_addr[IW-1:0]] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head      = 1'b0;
    w_head_from_tail = 1'b0;
    w_load_tail      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_load_head = 1'b1;
          w_state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        case ({w_push, w_pop})
          2'b11:   w_load_head = 1'b1;
          2'b10: begin
            w_load_tail = 1'b1;
            w_state_nxt = S_FULL;
          end
          2'b01:   w_state_nxt = S_EMPTY;
          default: w_state_nxt = S_ONE;
        endcase
      end
      S_FULL: begin
        if (w_pop) begin
          w_head_from_tail = 1'b1;
          w_state_nxt      = S_ONE;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Head holds its last value when the FIFO drains, as the CPU may still observe it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head_data <= '0;
      r_head_err  <= 1'b0;
      r_tail_data <= '0;
      r_tail_err  <= 1'b0;
    end else begin
      if (w_load_head) begin
        r_head_data <= w_rd_data;
        r_head_err  <= w_rd_err;
      end else if (w_head_from_tail) begin
        r_head_data <= r_tail_data;
        r_head_err  <= r_tail_err;
      end
      if (w_load_tail) begin
        r_tail_data <= w_rd_data;
        r_tail_err  <= w_rd_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_cnt <= '0;
    end else if (w_push && (r_fetch_cnt != 16'hFFFF)) begin
      r_fetch_cnt <= r_fetch_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: a negedge monitor predicts each accepted fetch
// from a shadow store and checks responses in order; scenario tasks add direct checks.
module tb_imem_responder;

  localparam int DEPTH = 8;
  localparam int AW    = 13;
  localparam int DW    = 16;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  int   n_pops;

  logic [DW-1:0] m_mem [DEPTH];
  logic [DW:0]   sb_q [$];

  imem_responder_if #(.AW(AW), .DW(DW)) bus ();

  imem_responder #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW:0] model_fetch(input logic [AW-1:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
    if (a >= AW'(DEPTH)) return {1'b1, {DW{1'b0}}};
`endif
    return {1'b0, m_mem[a[2:0]]};
  endfunction

  // Pop-side compare happens before the same-edge push, and the push reads the
  // shadow store before that edge's load: the old word wins a collision.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.resp_valid && bus.resp_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_underflow: got {err,data}=%h with nothing expected",
                   {bus.resp_err, bus.resp_data});
        end else begin
          logic [DW:0] exp;
          exp = sb_q.pop_front();
          if ({bus.resp_err, bus.resp_data} !== exp) begin
            n_errors++;
            $display("FAIL sb_resp: got {err,data}=%h expected %h",
                     {bus.resp_err, bus.resp_data}, exp);
          end
        end
        n_pops++;
      end
      if (bus.req_valid && bus.req_ready) sb_q.push_back(model_fetch(bus.req_addr));
      if (bus.ld_en) m_mem[bus.ld_addr[2:0]] = bus.ld_data;
    end
  end

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    @(posedge clk); #1;
    bus.ld_en   = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    int guard;
    guard         = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    @(negedge clk);
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_timeout: addr %h never accepted", a);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b0;
    bus.ld_en      = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    #1;
    expect_val("rst_req_ready",  32'(bus.req_ready),  32'd1);
    expect_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    expect_val("rst_resp_data",  32'(bus.resp_data),  32'd0);
    expect_val("rst_resp_err",   32'(bus.resp_err),   32'd0);
    expect_val("rst_fetch_cnt",  32'(bus.fetch_cnt),  32'd0);
    #22 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] words [8];
    int p0;
    words = '{16'h0000, 16'h2001, 16'h4002, 16'h6003, 16'ha004, 16'hc005, 16'h6206, 16'h8007};
    for (int i = 0; i < 8; i++) load(AW'(i), words[i]);
    bus.resp_ready = 1'b1;
    p0 = n_pops;
    for (int i = 0; i < 8; i++) begin
      issue(AW'(i));
      expect_val("b2b_latency_valid", 32'(bus.resp_valid), 32'd1);
      expect_val("b2b_head_data", 32'(bus.resp_data), 32'(words[i]));
    end
    repeat (3) @(posedge clk);
    #1;
    expect_val("b2b_pops", 32'(n_pops - p0), 32'd8);
    expect_val("b2b_fetch_cnt", 32'(bus.fetch_cnt), 32'd8);
    expect_val("b2b_drained", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic test_stall;
    int p0;
    p0 = n_pops;
    bus.resp_ready = 1'b0;
    issue(AW'(1));
    issue(AW'(2));
    expect_val("stall_full_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_addr  = AW'(3);
    repeat (2) begin
      @(negedge clk);
      expect_val("stall_ready_low", 32'(bus.req_ready), 32'd0);
      expect_val("stall_head_hold", 32'(bus.resp_data), 32'h2001);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    expect_val("stall_no_ready_from_pop", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    expect_val("stall_ready_after_pop", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    expect_val("stall_pops", 32'(n_pops - p0), 32'd3);
    expect_val("stall_sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic test_collision;
    bus.resp_ready = 1'b1;
    bus.ld_en      = 1'b1;
    bus.ld_addr    = AW'(5);
    bus.ld_data    = 16'hBEEF;
    issue(AW'(5));
    bus.ld_en = 1'b0;
    @(negedge clk);
    expect_val("collide_old_word", 32'(bus.resp_data), 32'hc005);
    @(posedge clk); #1;
    issue(AW'(5));
    @(negedge clk);
    expect_val("collide_new_word", 32'(bus.resp_data), 32'hBEEF);
    @(posedge clk); #1;
  endtask

  task automatic test_bounds;
    bus.resp_ready = 1'b1;
    issue(AW'(9));
    @(negedge clk);
`ifdef IMEM_BOUNDS_CHECK_EN
    expect_val("bounds_data", 32'(bus.resp_data), 32'h0000);
    expect_val("bounds_err",  32'(bus.resp_err),  32'd1);
`else
    expect_val("bounds_data", 32'(bus.resp_data), 32'h2001);
    expect_val("bounds_err",  32'(bus.resp_err),  32'd0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    bus.resp_ready = 1'b0;
    issue(AW'(2));
    issue(AW'(3));
    expect_val("midrst_full", 32'(bus.req_ready), 32'd0);
    #3 reset_n = 1'b0;
    #1;
    expect_val("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    expect_val("midrst_req_ready",  32'(bus.req_ready),  32'd1);
    expect_val("midrst_fetch_cnt",  32'(bus.fetch_cnt),  32'd0);
    sb_q.delete();
    #8 reset_n = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    issue(AW'(0));
    @(negedge clk);
    expect_val("midrst_store_kept_valid", 32'(bus.resp_valid), 32'd1);
    expect_val("midrst_store_kept_data",  32'(bus.resp_data),  32'h0000);
    @(posedge clk); #1;
    issue(AW'(3));
    @(negedge clk);
    expect_val("midrst_store_kept_3", 32'(bus.resp_data), 32'h6003);
    @(posedge clk); #1;
  endtask

  task automatic test_saturate;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    sb_q.delete();
    #4 reset_n = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 32'h10002; i++) begin
      bus.req_addr = AW'(i % 8);
      @(posedge clk); #1;
      if (i == 32'hFFFD) expect_val("sat_before", 32'(bus.fetch_cnt), 32'hFFFE);
      if (i == 32'hFFFE) expect_val("sat_reach",  32'(bus.fetch_cnt), 32'hFFFF);
    end
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_val("sat_hold", 32'(bus.fetch_cnt), 32'hFFFF);
    expect_val("sat_sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_pops   = 0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_collision();
    test_bounds();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
